// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for the six-source shared datapath bus.
// Grants one source at a time, holds the grant until the owner releases,
// drops its request, or reaches MAX_HOLD cycles, then inserts one idle
// turnaround cycle before the next owner.
//
// Ports:
//   clk       - system clock, rising-edge
//   rst       - synchronous active-high reset
//   req[5:0]  - per-source bus request
//   rel[5:0]  - per-source release strobe (only the owner's bit matters)
//   bSel[5:0] - one-hot grant to the bus mux select, 0 when no owner
//   gnt_id    - binary index of the current/last owner
//   bus_valid - high while bSel is non-zero
//   timeout   - one-cycle pulse when an ownership ends on the hold limit
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | nobody owns the bus, arbitrate every cycle
// OWN   | gnt_id owns the bus, cnt counts held cycles
// GAP   | one turnaround cycle with bSel = 0, arbitrate
module bus_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] req,
  input  logic [5:0] rel,
  output logic [5:0] bSel,
  output logic [2:0] gnt_id,
  output logic       bus_valid,
  output logic       timeout
);

  localparam int CW = $clog2(MAX_HOLD) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    ptr, ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [5:0]    bsel_nxt;
  logic [2:0]    gnt_nxt;
  logic          valid_nxt;
  logic          timeout_nxt;

  logic          win_found;
  logic [2:0]    win_id;
  logic          owner_req;
  logic          owner_rel;
  logic          hold_hit;
  logic          own_end;

  // (base + k) mod 6 for base in 0..5, k in 0..5
  function automatic logic [2:0] rr_index(input logic [2:0] base, input int k);
    logic [3:0] sum;
    sum = {1'b0, base} + 4'(k);
    if (sum >= 4'd6) sum = sum - 4'd6;
    return sum[2:0];
  endfunction

  // Walk the search order backwards so the first requester after ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (req[rr_index(ptr, k)]) begin
        win_found = 1'b1;
        win_id    = rr_index(ptr, k);
      end
    end
  end

  assign owner_req = req[gnt_id];
  assign owner_rel = rel[gnt_id];
  assign hold_hit  = (cnt == CW'(MAX_HOLD - 1));
  assign own_end   = owner_rel | ~owner_req | hold_hit;

  // State register, also holding the registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= 3'd0;
      cnt       <= '0;
      bSel      <= 6'd0;
      gnt_id    <= 3'd0;
      bus_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      bSel      <= bsel_nxt;
      gnt_id    <= gnt_nxt;
      bus_valid <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_GAP: state_nxt = win_found ? S_OWN : S_IDLE;
      S_OWN:         state_nxt = own_end ? S_GAP : S_OWN;
      default:       state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    bsel_nxt    = bSel;
    gnt_nxt     = gnt_id;
    valid_nxt   = bus_valid;
    timeout_nxt = 1'b0;
    case (state)
      S_IDLE, S_GAP: begin
        if (win_found) begin
          bsel_nxt  = 6'b000001 << win_id;
          gnt_nxt   = win_id;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          bsel_nxt  = 6'd0;
          valid_nxt = 1'b0;
        end
      end
      S_OWN: begin
        if (own_end) begin
          bsel_nxt    = 6'd0;
          valid_nxt   = 1'b0;
          ptr_nxt     = (gnt_id == 3'd5) ? 3'd0 : gnt_id + 3'd1;
          // release or request drop outranks the hold limit
          timeout_nxt = hold_hit & ~owner_rel & owner_req;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        bsel_nxt  = 6'd0;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule
